// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate generator pipe: instruction input side,
// decoded output side and illegal-opcode counter control.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic             cnt_clr;
  logic [CNT_W-1:0] illegal_count;

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready, cnt_clr,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag, illegal_count
  );

  modport master (
    output in_valid, in_inst, in_tag, out_ready, cnt_clr,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag, illegal_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: opcode-driven format decode and sign extension,
// registered behind a valid/ready handshake with a one-entry skid buffer.
//
// state    | meaning
// ST_EMPTY | OUT and SKID both empty
// ST_OUT   | OUT holds an entry, SKID empty
// ST_FULL  | OUT and SKID both hold entries; input stalled
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  imm_gen_pipe_if.slave   bus
);

  typedef enum logic [1:0] {ST_EMPTY, ST_OUT, ST_FULL} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  out_imm_q, skid_imm_q;
  logic [2:0]       out_fmt_q, skid_fmt_q;
  logic             out_ill_q, skid_ill_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;

  logic [31:0]      inst;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_ill;
  logic             accept;
  logic             load_out, load_skid, move_skid;

  assign inst = bus.in_inst;

  always_comb begin
    imm32   = 32'd0;
    dec_fmt = 3'd7;
    dec_ill = 1'b1;
    unique case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        dec_fmt = 3'd1;
        dec_ill = 1'b0;
        imm32   = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        dec_fmt = 3'd2;
        dec_ill = 1'b0;
        imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt = 3'd3;
        dec_ill = 1'b0;
        imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = 3'd4;
        dec_ill = 1'b0;
        imm32   = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = 3'd5;
        dec_ill = 1'b0;
        imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011: begin
        dec_fmt = 3'd0;
        dec_ill = 1'b0;
      end
      default: ;
    endcase
  end

  // All formats are already sign-extended to 32 bits; widen to XLEN by bit 31.
  assign dec_imm = XLEN'($signed(imm32));

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          if (accept) load_out = 1'b1;
          else        state_d  = ST_EMPTY;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          move_skid = 1'b1;
          state_d   = ST_OUT;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr)                                cnt_d = '0;
    else if (accept && dec_ill && (cnt_q != '1))    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_imm_q  <= '0;
      out_fmt_q  <= '0;
      out_ill_q  <= 1'b0;
      out_tag_q  <= '0;
      skid_imm_q <= '0;
      skid_fmt_q <= '0;
      skid_ill_q <= 1'b0;
      skid_tag_q <= '0;
    end else begin
      if (load_out) begin
        out_imm_q <= dec_imm;
        out_fmt_q <= dec_fmt;
        out_ill_q <= dec_ill;
        out_tag_q <= bus.in_tag;
      end else if (move_skid) begin
        out_imm_q <= skid_imm_q;
        out_fmt_q <= skid_fmt_q;
        out_ill_q <= skid_ill_q;
        out_tag_q <= skid_tag_q;
      end
      if (load_skid) begin
        skid_imm_q <= dec_imm;
        skid_fmt_q <= dec_fmt;
        skid_ill_q <= dec_ill;
        skid_tag_q <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = (state_q != ST_EMPTY);
  assign bus.out_imm       = out_imm_q;
  assign bus.out_fmt       = out_fmt_q;
  assign bus.out_illegal   = out_ill_q;
  assign bus.out_tag       = out_tag_q;
  assign bus.illegal_count = cnt_q;

endmodule
